read_reorder: RTL and testbench
===============================

READ_REORDER -- requirements
Module: read_reorder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, max in-flight reads and reorder entries (power of two, 2..64).
REQ-002 SHALL have parameter TAG_W, default $clog2(DEPTH), width of the memory tag.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  accelerator read request (buffer, offset) valid.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_buffer  in  8  target buffer index.
REQ-008 SHALL have port req_offset  in  t_request_cmd_offset  cache-line offset within the buffer.
REQ-009 SHALL have port mem_req_valid  out  1  read issued to memory side.
REQ-010 SHALL have port mem_req_ready  in  1  memory side can take a read this cycle.
REQ-011 SHALL have port mem_req_buffer, mem_req_offset, mem_req_tag  out  8/t_request_cmd_offset/TAG_W  issued read fields.
REQ-012 SHALL have port mem_rsp_valid, mem_rsp_tag, mem_rsp_data  in  1/TAG_W/512  read response, any order.
REQ-013 SHALL have port out_valid, out_ready  out/in  1/1  in-order data handshake to accelerator.
REQ-014 SHALL have port out_data, out_offset  out  512/t_request_cmd_offset  response data and its original offset.
REQ-015 SHALL have port busy  out  1  high while any entry allocated.
REQ-016 SHALL have port err_tag  out  1  sticky: response for an unallocated tag.

Function
REQ-017 SHALL pass requests straight through: mem_req_valid = req_valid && !full; req_ready = mem_req_ready && !full; fields combinational from req_*.
REQ-018 SHALL assign mem_req_tag = alloc_ptr[TAG_W-1:0]; on accept, store offset in entry, mark entry pending, advance alloc_ptr by 1 (TAG_W+1 bits, wraps).
REQ-019 SHALL define count = alloc_ptr - drain_ptr (TAG_W+1 bit arithmetic); full = (count == DEPTH); empty = (count == 0).
REQ-020 SHALL, on mem_rsp_valid with a pending, not-yet-filled tag, write mem_rsp_data into that entry and set its filled bit in the same edge.
REQ-021 SHALL, on mem_rsp_valid with a tag not pending or already filled, drop the data, change no state, and set err_tag (cleared only by reset).
REQ-022 SHALL drive out_valid = !empty && filled[drain_ptr]; out_data/out_offset from entry drain_ptr; zero-bubble, no registered output stage.
REQ-023 SHALL, on out_valid && out_ready, clear pending/filled of entry drain_ptr and advance drain_ptr by 1.
REQ-024 SHALL allow accept, response fill and drain in one cycle; a drain when full frees a slot visible to req_ready the next cycle only.
REQ-025 SHALL accept a response and a new allocation to the same index in one cycle never (index cannot be both free and pending); no special case required.
REQ-026 SHALL hold out_data/out_offset stable while out_valid && !out_ready.
REQ-027 SHALL drive busy = !empty.

Reset
REQ-028 SHALL, on reset low, asynchronously clear alloc_ptr, drain_ptr, all pending/filled bits and err_tag; outputs: req_ready 0, mem_req_valid 0, out_valid 0, busy 0, err_tag 0.
REQ-029 SHALL not reset data storage; out_data undefined while out_valid is 0.
REQ-030 SHALL, on reset mid-operation, discard all in-flight entries; responses arriving after reset release set err_tag.

Structure
REQ-031 SHALL take t_request_cmd_offset and a new typedef t_cl (512-bit line) from hc_pkg; HC_ROB_DEPTH default constant lives in hc_pkg.
REQ-032 SHALL place data storage in sub-module read_reorder_ram (1 write port, 1 async read port, DEPTH x 512, no reset).
REQ-033 SHALL keep pointer, flag and error logic in read_reorder itself.

Verification
REQ-034 SHALL cover: 4 requests offsets 0..3, responses in order tags 0..3 -> out_offset 0,1,2,3 with matching data, busy falls after 4th drain.
REQ-035 SHALL cover: 4 requests, responses tags 3,2,1,0 -> no out_valid until tag 0 fills, then offsets 0,1,2,3 on consecutive cycles with out_ready=1.
REQ-036 SHALL cover: 8 requests with out_ready=0, all filled -> req_ready 0 at 9th; one drain -> req_ready 1 next cycle, 9th issues with tag 0.
REQ-037 SHALL cover: mem_req_ready=0 for 5 cycles with req_valid=1 -> no accept, no alloc_ptr change, req fields held by source.
REQ-038 SHALL cover: response with tag 5 when only tags 0..1 pending, and duplicate tag 0 response -> err_tag=1, outputs unchanged.
REQ-039 SHALL cover: reset low with 3 entries pending -> out_valid 0, busy 0 immediately; late tag 1 response sets err_tag.

Source files
------------

// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared host-channel types and defaults for the read reorder path
package hc_pkg;

   localparam int HC_ROB_DEPTH = 8;
   localparam int HC_OFFSET_W  = 16;

   typedef logic [HC_OFFSET_W-1:0] t_request_cmd_offset;
   typedef logic [511:0]           t_cl;

endpackage

// File: rtl/read_reorder_ram.sv
// rtl/read_reorder_ram.sv - reorder data storage, one write port and one async read port
module read_reorder_ram
   import hc_pkg::*;
#(
   parameter int DEPTH  = HC_ROB_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  t_cl               i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output t_cl               o_rd_data
);

   t_cl r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/read_reorder.sv
// rtl/read_reorder.sv - tags outgoing reads and returns out-of-order responses in request order
module read_reorder
   import hc_pkg::*;
#(
   parameter int DEPTH = HC_ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [7:0]          req_buffer,
   input  t_request_cmd_offset req_offset,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [7:0]          mem_req_buffer,
   output t_request_cmd_offset mem_req_offset,
   output logic [TAG_W-1:0]    mem_req_tag,
   input  logic                mem_rsp_valid,
   input  logic [TAG_W-1:0]    mem_rsp_tag,
   input  t_cl                 mem_rsp_data,
   output logic                out_valid,
   input  logic                out_ready,
   output t_cl                 out_data,
   output t_request_cmd_offset out_offset,
   output logic                busy,
   output logic                err_tag
);

   logic [TAG_W:0]      r_alloc_ptr;
   logic [TAG_W:0]      r_drain_ptr;
   logic [DEPTH-1:0]    r_pending;
   logic [DEPTH-1:0]    r_filled;
   logic                r_err_tag;
   t_request_cmd_offset r_offset [DEPTH];

   logic [TAG_W:0]      w_count;
   logic                w_full;
   logic                w_empty;
   logic [TAG_W-1:0]    w_alloc_idx;
   logic [TAG_W-1:0]    w_drain_idx;
   logic                w_accept;
   logic                w_fill;
   logic                w_rsp_bad;
   logic                w_drain;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   assign w_count     = r_alloc_ptr - r_drain_ptr;
   assign w_full      = (w_count == (TAG_W+1)'(DEPTH));
   assign w_empty     = (w_count == '0);
   assign w_alloc_idx = r_alloc_ptr[TAG_W-1:0];
   assign w_drain_idx = r_drain_ptr[TAG_W-1:0];

   // Gating with reset keeps the request handshake quiet while reset is held.
   assign req_ready      = reset & mem_req_ready & ~w_full;
   assign mem_req_valid  = reset & req_valid & ~w_full;
   assign mem_req_buffer = req_buffer;
   assign mem_req_offset = req_offset;
   assign mem_req_tag    = w_alloc_idx;
   assign w_accept       = req_valid & req_ready;

   assign w_fill    = mem_rsp_valid & r_pending[mem_rsp_tag] & ~r_filled[mem_rsp_tag];
   assign w_rsp_bad = mem_rsp_valid & ~w_fill;

   assign out_valid  = ~w_empty & r_filled[w_drain_idx];
   assign out_offset = r_offset[w_drain_idx];
   assign w_drain    = out_valid & out_ready;
   assign busy       = ~w_empty;
   assign err_tag    = r_err_tag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_alloc_ptr <= '0;
         r_drain_ptr <= '0;
         r_pending   <= '0;
         r_filled    <= '0;
         r_err_tag   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alloc_ptr            <= r_alloc_ptr + (TAG_W+1)'(1);
            r_pending[w_alloc_idx] <= 1'b1;
         end
         if (w_fill) begin
            r_filled[mem_rsp_tag] <= 1'b1;
         end
         // Drain never aliases accept or fill: its slot is filled, so it is neither free nor fillable.
         if (w_drain) begin
            r_pending[w_drain_idx] <= 1'b0;
            r_filled[w_drain_idx]  <= 1'b0;
            r_drain_ptr            <= r_drain_ptr + (TAG_W+1)'(1);
         end
         if (w_rsp_bad) begin
            r_err_tag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_offset[w_alloc_idx] <= req_offset;
      end
   end

   read_reorder_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (TAG_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_fill),
      .i_wr_addr (mem_rsp_tag),
      .i_wr_data (mem_rsp_data),
      .i_rd_addr (w_drain_idx),
      .o_rd_data (out_data)
   );

endmodule

// File: tb/tb_read_reorder.sv
// tb/tb_read_reorder.sv - directed self-checking bench for read_reorder
module tb_read_reorder;
   import hc_pkg::*;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                req_valid;
   logic                req_ready;
   logic [7:0]          req_buffer;
   t_request_cmd_offset req_offset;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [7:0]          mem_req_buffer;
   t_request_cmd_offset mem_req_offset;
   logic [TAG_W-1:0]    mem_req_tag;
   logic                mem_rsp_valid;
   logic [TAG_W-1:0]    mem_rsp_tag;
   t_cl                 mem_rsp_data;
   logic                out_valid;
   logic                out_ready;
   t_cl                 out_data;
   t_request_cmd_offset out_offset;
   logic                busy;
   logic                err_tag;

   int n_vec = 0;
   int n_err = 0;

   read_reorder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_buffer     (req_buffer),
      .req_offset     (req_offset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_buffer (mem_req_buffer),
      .mem_req_offset (mem_req_offset),
      .mem_req_tag    (mem_req_tag),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_tag    (mem_rsp_tag),
      .mem_rsp_data   (mem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_offset     (out_offset),
      .busy           (busy),
      .err_tag        (err_tag)
   );

   always #5 clk = ~clk;

   function automatic t_cl mk(input int v);
      t_cl d;
      for (int w = 0; w < 16; w++) begin
         d[w*32 +: 32] = 32'hA500_0000 + 32'(v) + 32'(w << 8);
      end
      return d;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid     = 1'b0;
      req_buffer    = 8'h00;
      req_offset    = '0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_tag   = '0;
      mem_rsp_data  = '0;
      out_ready     = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      idle_inputs();
      tick();
      reset = 1'b1;
   endtask

   task automatic send_req(input int off, input int exp_tag);
      req_valid  = 1'b1;
      req_offset = 16'(off);
      req_buffer = 8'(8'h40 + off);
      #1;
      check("req_ready", 512'(req_ready), 512'(1));
      check("req_tag", 512'(mem_req_tag), 512'(exp_tag));
      check("req_buffer", 512'(mem_req_buffer), 512'(8'(8'h40 + off)));
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send_rsp(input int tag, input t_cl data);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = TAG_W'(tag);
      mem_rsp_data  = data;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      // Reset state, with a request already offered.
      reset = 1'b0;
      idle_inputs();
      req_valid = 1'b1;
      #2;
      check("rst_req_ready", 512'(req_ready), 512'(0));
      check("rst_mem_req_valid", 512'(mem_req_valid), 512'(0));
      check("rst_out_valid", 512'(out_valid), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_err_tag", 512'(err_tag), 512'(0));
      do_reset();

      // In-order responses.
      for (int i = 0; i < 4; i++) send_req(i, i);
      check("t1_busy", 512'(busy), 512'(1));
      check("t1_out_valid_idle", 512'(out_valid), 512'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_tag   = TAG_W'(i);
         mem_rsp_data  = mk(i);
         tick();
         check("t1_out_valid", 512'(out_valid), 512'(1));
         check("t1_out_offset", 512'(out_offset), 512'(i));
         check("t1_out_data", out_data, mk(i));
      end
      mem_rsp_valid = 1'b0;
      check("t1_busy_last", 512'(busy), 512'(1));
      tick();
      check("t1_busy_done", 512'(busy), 512'(0));
      check("t1_out_valid_done", 512'(out_valid), 512'(0));
      check("t1_err_tag", 512'(err_tag), 512'(0));

      // Reverse-order responses.
      do_reset();
      for (int i = 0; i < 4; i++) send_req(i, i);
      out_ready = 1'b1;
      for (int t = 3; t >= 1; t--) begin
         send_rsp(t, mk(100 + t));
         check("t2_hold_out_valid", 512'(out_valid), 512'(0));
      end
      send_rsp(0, mk(100));
      for (int i = 0; i < 4; i++) begin
         check("t2_out_valid", 512'(out_valid), 512'(1));
         check("t2_out_offset", 512'(out_offset), 512'(i));
         check("t2_out_data", out_data, mk(100 + i));
         tick();
      end
      check("t2_busy_done", 512'(busy), 512'(0));

      // Full, then one drain frees a slot for the following cycle.
      do_reset();
      for (int i = 0; i < 8; i++) send_req(16'h20 + i, i);
      for (int i = 0; i < 8; i++) send_rsp(i, mk(16'h20 + i));
      check("t3_out_offset0", 512'(out_offset), 512'(16'h20));
      check("t3_out_data0", out_data, mk(16'h20));
      req_valid  = 1'b1;
      req_offset = 16'h0099;
      req_buffer = 8'h99;
      #1;
      check("t3_full_req_ready", 512'(req_ready), 512'(0));
      check("t3_full_mem_req_valid", 512'(mem_req_valid), 512'(0));
      check("t3_full_busy", 512'(busy), 512'(1));
      out_ready = 1'b1;
      #1;
      check("t3_drain_req_ready", 512'(req_ready), 512'(0));
      check("t3_held_data", out_data, mk(16'h20));
      tick();
      out_ready = 1'b0;
      check("t3_after_req_ready", 512'(req_ready), 512'(1));
      check("t3_after_mem_req_valid", 512'(mem_req_valid), 512'(1));
      check("t3_ninth_tag", 512'(mem_req_tag), 512'(0));
      check("t3_ninth_offset", 512'(mem_req_offset), 512'(16'h0099));
      tick();
      req_valid = 1'b0;
      check("t3_refull_req_ready", 512'(req_ready), 512'(0));
      check("t3_next_offset", 512'(out_offset), 512'(16'h21));

      // Memory side stalled.
      do_reset();
      mem_req_ready = 1'b0;
      req_valid     = 1'b1;
      req_offset    = 16'h0055;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t4_req_ready", 512'(req_ready), 512'(0));
         check("t4_mem_req_valid", 512'(mem_req_valid), 512'(1));
         check("t4_tag", 512'(mem_req_tag), 512'(0));
         tick();
      end
      check("t4_busy", 512'(busy), 512'(0));
      mem_req_ready = 1'b1;
      #1;
      check("t4_release_ready", 512'(req_ready), 512'(1));
      tick();
      req_valid = 1'b0;
      check("t4_accepted_busy", 512'(busy), 512'(1));
      check("t4_next_tag", 512'(mem_req_tag), 512'(1));

      // Duplicate response for an already-filled tag.
      do_reset();
      send_req(7, 0);
      send_req(8, 1);
      send_rsp(0, mk(200));
      check("t5_err_clean", 512'(err_tag), 512'(0));
      check("t5_out_data", out_data, mk(200));
      send_rsp(0, mk(201));
      check("t5_dup_err", 512'(err_tag), 512'(1));
      check("t5_dup_data", out_data, mk(200));
      check("t5_dup_offset", 512'(out_offset), 512'(7));
      check("t5_dup_out_valid", 512'(out_valid), 512'(1));

      // Response for an unallocated tag.
      do_reset();
      check("t5_err_cleared", 512'(err_tag), 512'(0));
      send_req(9, 0);
      send_req(10, 1);
      send_rsp(5, mk(300));
      check("t5_unalloc_err", 512'(err_tag), 512'(1));
      check("t5_unalloc_out_valid", 512'(out_valid), 512'(0));
      check("t5_unalloc_busy", 512'(busy), 512'(1));
      check("t5_unalloc_tag", 512'(mem_req_tag), 512'(2));

      // Reset while entries are in flight.
      do_reset();
      for (int i = 0; i < 3; i++) send_req(i, i);
      send_rsp(0, mk(400));
      check("t6_pre_out_valid", 512'(out_valid), 512'(1));
      reset = 1'b0;
      #1;
      check("t6_rst_out_valid", 512'(out_valid), 512'(0));
      check("t6_rst_busy", 512'(busy), 512'(0));
      tick();
      reset = 1'b1;
      send_rsp(1, mk(401));
      check("t6_late_err", 512'(err_tag), 512'(1));
      check("t6_late_out_valid", 512'(out_valid), 512'(0));
      check("t6_late_busy", 512'(busy), 512'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
